// File: rtl/ppi_bus_master.sv
// rtl/ppi_bus_master.sv - host-side initiator for an 8255-compatible PPI bus
//
// Turns single-beat valid/ready register requests into timed PPI cycles
// (SETUP -> STROBE -> HOLD). It also generates the PPI reset pulse that
// follows a system reset.
//
// Ports:
//   CLK, RESET         clock and synchronous active-high reset
//   req_valid/ready    host request handshake (ready only in IDLE)
//   req_write          1 = PPI write, 0 = PPI read
//   req_addr           PPI register select
//   req_wdata          write data
//   rsp_valid          one-cycle completion pulse (first HOLD cycle)
//   rsp_rdata          last read data
//   A, CS, READ, WRITE PPI address and active-low strobes
//   DATA               PPI data bus, driven only during write cycles
//   PPI_RESET          active-high reset to the PPI
module ppi_bus_master #(
    parameter int SETUP_CYCLES  = 1,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1,
    parameter int RST_PULSE     = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [1:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic [1:0] A,
    output logic       CS,
    output logic       READ,
    output logic       WRITE,
    inout  wire  [7:0] DATA,
    output logic       PPI_RESET
);

    // Zero-length phases are clamped to one cycle.
    localparam logic [7:0] SETUP_LEN  = (SETUP_CYCLES  < 1) ? 8'd1 : 8'(SETUP_CYCLES);
    localparam logic [7:0] STROBE_LEN = (STROBE_CYCLES < 1) ? 8'd1 : 8'(STROBE_CYCLES);
    localparam logic [7:0] HOLD_LEN   = (HOLD_CYCLES   < 1) ? 8'd1 : 8'(HOLD_CYCLES);
    localparam logic [7:0] RST_LEN    = 8'(RST_PULSE);

    typedef enum logic [2:0] {
        ST_RST_WAIT,
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       wr_q, wr_d;
    logic [1:0] a_q, a_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       cs_q, cs_d;
    logic       rd_n_q, rd_n_d;
    logic       wr_n_q, wr_n_d;
    logic       oe_q, oe_d;
    logic       ready_q, ready_d;
    logic       rspv_q, rspv_d;
    logic       prst_q, prst_d;
    logic       last;
    logic       busy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - 8'd1;
        wr_d    = wr_q;
        a_d     = a_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        // The counter holds the number of cycles left in the current phase,
        // so a value of 1 marks the final cycle.
        last    = (cnt_q <= 8'd1);

        case (state_q)
            ST_RST_WAIT: begin
                if (last) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (req_valid && ready_q) begin
                    state_d = ST_SETUP;
                    cnt_d   = SETUP_LEN;
                    wr_d    = req_write;
                    a_d     = req_addr;
                    wdata_d = req_wdata;
                end
            end
            ST_SETUP: begin
                if (last) begin
                    state_d = ST_STROBE;
                    cnt_d   = STROBE_LEN;
                end
            end
            ST_STROBE: begin
                if (last) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LEN;
                    // The PPI has had the whole strobe window to drive the bus.
                    if (!wr_q) begin
                        rdata_d = DATA;
                    end
                end
            end
            ST_HOLD: begin
                if (last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_RST_WAIT;
            end
        endcase

        // Bus outputs are decoded from the next state so that the registered
        // pins line up with the state they belong to.
        busy_d    = (state_d == ST_SETUP) || (state_d == ST_STROBE) || (state_d == ST_HOLD);
        cs_d      = !busy_d;
        rd_n_d    = !((state_d == ST_STROBE) && !wr_d);
        wr_n_d    = !((state_d == ST_STROBE) && wr_d);
        oe_d      = busy_d && wr_d;
        ready_d   = (state_d == ST_IDLE);
        prst_d    = (state_d == ST_RST_WAIT);
        rspv_d    = (state_q == ST_STROBE) && (state_d == ST_HOLD);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_RST_WAIT;
            cnt_q   <= RST_LEN;
            wr_q    <= 1'b0;
            a_q     <= 2'd0;
            wdata_q <= 8'd0;
            rdata_q <= 8'd0;
            cs_q    <= 1'b1;
            rd_n_q  <= 1'b1;
            wr_n_q  <= 1'b1;
            oe_q    <= 1'b0;
            ready_q <= 1'b0;
            rspv_q  <= 1'b0;
            prst_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            a_q     <= a_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cs_q    <= cs_d;
            rd_n_q  <= rd_n_d;
            wr_n_q  <= wr_n_d;
            oe_q    <= oe_d;
            ready_q <= ready_d;
            rspv_q  <= rspv_d;
            prst_q  <= prst_d;
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = rspv_q;
    assign rsp_rdata = rdata_q;
    assign A         = a_q;
    assign CS        = cs_q;
    assign READ      = rd_n_q;
    assign WRITE     = wr_n_q;
    assign PPI_RESET = prst_q;
    assign DATA      = oe_q ? wdata_q : 8'bz;

endmodule
